nonce_scheduler: RTL and testbench
==================================

Name: nonce_scheduler

Overview:
- Parametrised successor to the single-core block solver.
- Splits an inclusive nonce range [nonce_base, nonce_limit] into fixed-size chunks and dispatches them to NUM_LANES external SHA-256d hashing lanes.
- Compares every returned hash against the target, and reports the winning nonce or range exhaustion on a state_out code compatible with the existing solver.
- Sits between the host/register interface and the lane array.

Parameters:
- NUM_LANES, 4: number of hashing lanes (1..16).
- NONCE_W, 32: nonce width.
- CHUNK_LOG2, 8: nonces per dispatched job = 2**CHUNK_LOG2 (final chunk may be shorter).
- HASH_W, 256: hash/target width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: latch range/target, begin search
- stop  in  1  one-cycle pulse: abort search, return to IDLE
- nonce_base  in  NONCE_W  first nonce (inclusive)
- nonce_limit  in  NONCE_W  last nonce (inclusive)
- target  in  HASH_W  hit when hash <= target, unsigned, bit HASH_W-1 is MSB
- lane_job_valid  out  NUM_LANES  per-lane job offer
- lane_job_ready  in  NUM_LANES  per-lane job accept
- lane_job_nonce  out  NUM_LANES*NONCE_W  chunk start nonce, lane i at slice i
- lane_job_count  out  NUM_LANES*(CHUNK_LOG2+1)  nonces in chunk (1..2**CHUNK_LOG2)
- lane_abort  out  1  one-cycle pulse: all lanes drop current job
- lane_res_valid  in  NUM_LANES  one-cycle result strobe
- lane_res_nonce  in  NUM_LANES*NONCE_W  nonce of the result
- lane_res_hash  in  NUM_LANES*HASH_W  final hash of the result
- lane_job_done  in  NUM_LANES  one-cycle pulse: lane finished its chunk
- state_out  out  3  0 IDLE, 1 RUN, 2 FOUND, 3 EXHAUSTED, 4 DRAIN
- current_nonce  out  NONCE_W  next nonce to dispatch; the found nonce in FOUND
- found_nonce  out  NONCE_W  winning nonce, valid in FOUND

Behaviour:
- Reset: state IDLE, all lane_job_valid 0, lane_job_nonce/count 0, lane_abort 0, current_nonce 0, found_nonce 0, all lane busy flags 0.
- IDLE:
  - start latches base, limit and target.
  - Internal next pointer is NONCE_W+1 bits, initialised to base.
  - Enter RUN next cycle. If base > limit, enter EXHAUSTED instead.
- RUN, dispatch:
  - At most one new offer per cycle, to the lowest-index lane that is neither busy nor already offered.
  - count = min(2**CHUNK_LOG2, limit - next + 1).
  - The offer is held stable until ready; the handshake is valid & ready in the same cycle.
  - On handshake: lane busy=1, next += count.
  - Dispatch stops once next > limit, using the (NONCE_W+1)-bit compare. limit = all-ones therefore never wraps to 0.
- RUN, results:
  - Each valid result is compared (hash <= target). Simultaneous results from several lanes are allowed.
  - Any hit: the lowest-index hitting lane wins, found_nonce is registered, and lane_abort pulses next cycle.
  - Enter FOUND; all valid offers and busy flags are cleared.
- lane_job_done clears that lane's busy flag.
- EXHAUSTED: entered when next > limit, no busy lanes, no valid offers, and no hit this cycle. A hit in the same cycle as the exhaustion condition goes to FOUND.
- stop in RUN:
  - Pulse lane_abort, enter DRAIN.
  - DRAIN ignores results and moves to IDLE after 2 cycles, so in-flight result strobes are flushed.
  - stop in FOUND/EXHAUSTED goes directly to IDLE.
- start in FOUND/EXHAUSTED restarts as from IDLE. start is ignored in RUN/DRAIN.
- start and stop in the same cycle: stop wins.
- Results arriving outside RUN are ignored. Latency from hitting result strobe to state_out=2 is 1 cycle.
- Reset mid-search: all outputs return to reset values immediately (async); no abort pulse is issued.

Optional Feature:
- Macro NONCE_SCHED_SHARE_EN.
- When defined, adds ports:
  - share_target in HASH_W
  - share_pulse out 1
  - share_nonce out NONCE_W
  - share_count out 32
- In RUN, any result with hash <= share_target (and not a block hit) registers share_nonce from the lowest-index such lane, pulses share_pulse for 1 cycle, and increments share_count (saturating).
- share_count clears on start.
- Undefined: ports absent, no share logic.

Decomposition:
- Package miner_pkg: state_out enum (IDLE/RUN/FOUND/EXHAUSTED/DRAIN as 3-bit codes), default widths, and the CHUNK count-width function.
- One sub-module, lane_prio_pick: parametrised lowest-index one-hot/index picker. Used for dispatch-lane choice and for hit arbitration.

Test Plan:
- NUM_LANES=4, CHUNK_LOG2=8, base=0, limit=0x3FF, target=0, lanes never hit -> 4 jobs at nonces 0x000/0x100/0x200/0x300 with count 256, then EXHAUSTED (state_out=3) after last lane_job_done.
- Target 256'h00000000000000000440C4..00; lane 2 returns nonce 32'h9c9a4fc0 with hash below target -> state_out=2 next cycle, found_nonce=current_nonce=32'h9c9a4fc0, lane_abort one pulse.
- Lanes 1 and 3 hit in the same cycle (nonces 0x150, 0x350) -> found_nonce=0x150.
- base=0xFFFFFF80, limit=0xFFFFFFFF -> single job, count 128, no wrap, EXHAUSTED.
- Hold lane_job_ready=0 on lane 0 for 5 cycles -> offer nonce/count stable throughout; then stop -> abort pulse, DRAIN 2 cycles, IDLE.
- base=10, limit=5, start -> EXHAUSTED next cycle with no job offered. With NONCE_SCHED_SHARE_EN: 3 share hits -> share_count=3, three share_pulses.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and defaults for the nonce scheduler slice.
// The scheduler's optional share reporting is built only when NONCE_SCHED_SHARE_EN is defined.
package miner_pkg;

  // state_out codes, kept compatible with the single-core solver.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_FOUND     = 3'd2,
    ST_EXHAUSTED = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_NONCE_W    = 32;
  localparam int DEF_CHUNK_LOG2 = 8;
  localparam int DEF_HASH_W     = 256;

  // A chunk count runs 1..2**chunk_log2, so it needs one bit more than the log.
  function automatic int chunk_count_w(input int chunk_log2);
    return chunk_log2 + 1;
  endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Lane-array bus between the nonce scheduler (master) and the hashing lanes (slave).
//
// Job handshake: per lane i, lane_job_valid[i] is an offer that stays asserted with
// lane_job_nonce/lane_job_count slice i held stable until the lane accepts it; the job
// transfers in exactly the cycle where lane_job_valid[i] & lane_job_ready[i] is high.
// lane_res_valid, lane_job_done and lane_abort are single-cycle strobes without back-pressure.
interface nonce_scheduler_if #(
  parameter int NUM_LANES  = miner_pkg::DEF_NUM_LANES,
  parameter int NONCE_W    = miner_pkg::DEF_NONCE_W,
  parameter int CHUNK_LOG2 = miner_pkg::DEF_CHUNK_LOG2,
  parameter int HASH_W     = miner_pkg::DEF_HASH_W
);

  logic [NUM_LANES-1:0]                lane_job_valid;
  logic [NUM_LANES-1:0]                lane_job_ready;
  logic [NUM_LANES*NONCE_W-1:0]        lane_job_nonce;
  logic [NUM_LANES*(CHUNK_LOG2+1)-1:0] lane_job_count;
  logic                                lane_abort;
  logic [NUM_LANES-1:0]                lane_res_valid;
  logic [NUM_LANES*NONCE_W-1:0]        lane_res_nonce;
  logic [NUM_LANES*HASH_W-1:0]         lane_res_hash;
  logic [NUM_LANES-1:0]                lane_job_done;

  modport master (
    output lane_job_valid, lane_job_nonce, lane_job_count, lane_abort,
    input  lane_job_ready, lane_res_valid, lane_res_nonce, lane_res_hash, lane_job_done
  );

  modport slave (
    input  lane_job_valid, lane_job_nonce, lane_job_count, lane_abort,
    output lane_job_ready, lane_res_valid, lane_res_nonce, lane_res_hash, lane_job_done
  );

endinterface

// File: rtl/lane_prio_pick.sv
// Lowest-index priority picker: one-hot grant of the lowest set request bit.
module lane_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);

  // Isolate the lowest set bit with the two's-complement trick.
  always_comb begin
    grant = req & (~req + N'(1));
    any   = |req;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: splits [nonce_base, nonce_limit] into chunks, dispatches them to
// NUM_LANES hashing lanes, and checks every returned hash against the target.
// Optional share reporting (share_target/share_pulse/share_nonce/share_count) is
// built when NONCE_SCHED_SHARE_EN is defined.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int NONCE_W    = DEF_NONCE_W,
  parameter int CHUNK_LOG2 = DEF_CHUNK_LOG2,
  parameter int HASH_W     = DEF_HASH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic [HASH_W-1:0]  target,
  nonce_scheduler_if.master  lane,
`ifdef NONCE_SCHED_SHARE_EN
  input  logic [HASH_W-1:0]  share_target,
  output logic               share_pulse,
  output logic [NONCE_W-1:0] share_nonce,
  output logic [31:0]        share_count,
`endif
  output logic [2:0]         state_out,
  output logic [NONCE_W-1:0] current_nonce,
  output logic [NONCE_W-1:0] found_nonce
);

  localparam int CNT_W = chunk_count_w(CHUNK_LOG2);
  // One extra pointer bit so that stepping past an all-ones limit cannot wrap to 0.
  localparam int PTR_W = NONCE_W + 1;
  localparam logic [PTR_W-1:0] CHUNK_SZ = PTR_W'(1) << CHUNK_LOG2;

  state_e                       state_q, state_d;
  logic [PTR_W-1:0]             nxt_q, limit_q;
  logic [HASH_W-1:0]            target_q;
  logic [NONCE_W-1:0]           found_q;
  logic [NUM_LANES-1:0]         busy_q, offer_q;
  logic [NUM_LANES*NONCE_W-1:0] offer_nonce_q;
  logic [NUM_LANES*CNT_W-1:0]   offer_count_q;
  logic                         abort_q, drain_q;

  logic [NUM_LANES-1:0] hit, hit_oh, free_oh, handshake;
  logic                 hit_any, free_any;
  logic [NONCE_W-1:0]   hit_nonce;
  logic [CNT_W-1:0]     chunk_cnt, hs_cnt;
  logic [PTR_W-1:0]     remaining;
  logic                 ptr_done, want_offer, start_ok;

  lane_prio_pick #(.N(NUM_LANES)) u_hit_pick (
    .req   (hit),
    .grant (hit_oh),
    .any   (hit_any)
  );

  lane_prio_pick #(.N(NUM_LANES)) u_free_pick (
    .req   (~busy_q & ~offer_q),
    .grant (free_oh),
    .any   (free_any)
  );

  // Per-lane target comparison of this cycle's result strobes.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit[i] = lane.lane_res_valid[i] &&
               (lane.lane_res_hash[i*HASH_W +: HASH_W] <= target_q);
    end
  end

  // Winner nonce and dispatch bookkeeping (chunk size, accepted count, offer decision).
  always_comb begin
    hit_nonce = '0;
    hs_cnt    = '0;
    handshake = offer_q & lane.lane_job_ready;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit_oh[i]) hit_nonce = hit_nonce | lane.lane_res_nonce[i*NONCE_W +: NONCE_W];
      if (handshake[i]) hs_cnt = hs_cnt | offer_count_q[i*CNT_W +: CNT_W];
    end
    remaining = limit_q - nxt_q + PTR_W'(1);
    chunk_cnt = (remaining < CHUNK_SZ) ? CNT_W'(remaining) : CNT_W'(CHUNK_SZ);
    ptr_done  = nxt_q > limit_q;
    // Only one offer is outstanding at a time, so every offer carries a fresh pointer.
    want_offer = (state_q == ST_RUN) && !stop && !hit_any && (offer_q == '0) &&
                 !ptr_done && free_any;
    start_ok   = start && !stop &&
                 ((state_q == ST_IDLE) || (state_q == ST_FOUND) || (state_q == ST_EXHAUSTED));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop takes priority over start and over a hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = (nonce_base > nonce_limit) ? ST_EXHAUSTED : ST_RUN;
      end
      ST_RUN: begin
        if (stop)         state_d = ST_DRAIN;
        else if (hit_any) state_d = ST_FOUND;
        else if (ptr_done && (busy_q == '0) && (offer_q == '0)) state_d = ST_EXHAUSTED;
      end
      ST_FOUND, ST_EXHAUSTED: begin
        if (stop)          state_d = ST_IDLE;
        else if (start_ok) state_d = (nonce_base > nonce_limit) ? ST_EXHAUSTED : ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Range latch, dispatch pointer, lane offers/busy flags, found nonce and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_q         <= '0;
      limit_q       <= '0;
      target_q      <= '0;
      found_q       <= '0;
      busy_q        <= '0;
      offer_q       <= '0;
      offer_nonce_q <= '0;
      offer_count_q <= '0;
      abort_q       <= 1'b0;
      drain_q       <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      // drain_q marks the second DRAIN cycle.
      drain_q <= (state_q == ST_DRAIN) && !drain_q;
      busy_q  <= busy_q & ~lane.lane_job_done;
      if (start_ok) begin
        nxt_q    <= {1'b0, nonce_base};
        limit_q  <= {1'b0, nonce_limit};
        target_q <= target;
        busy_q   <= '0;
        offer_q  <= '0;
      end else if (state_q == ST_RUN) begin
        if (stop || hit_any) begin
          abort_q <= 1'b1;
          busy_q  <= '0;
          offer_q <= '0;
          if (!stop) found_q <= hit_nonce;
        end else begin
          busy_q  <= (busy_q & ~lane.lane_job_done) | handshake;
          offer_q <= (offer_q & ~handshake) | (want_offer ? free_oh : '0);
          if (|handshake) nxt_q <= nxt_q + PTR_W'(hs_cnt);
          for (int i = 0; i < NUM_LANES; i++) begin
            if (want_offer && free_oh[i]) begin
              offer_nonce_q[i*NONCE_W +: NONCE_W] <= nxt_q[NONCE_W-1:0];
              offer_count_q[i*CNT_W +: CNT_W]     <= chunk_cnt;
            end
          end
        end
      end
    end
  end

`ifdef NONCE_SCHED_SHARE_EN
  logic [NUM_LANES-1:0] share_hit, share_oh;
  logic                 share_any;
  logic [NONCE_W-1:0]   share_nonce_d;

  lane_prio_pick #(.N(NUM_LANES)) u_share_pick (
    .req   (share_hit),
    .grant (share_oh),
    .any   (share_any)
  );

  // Results meeting the share target but not the block target.
  always_comb begin
    share_hit     = '0;
    share_nonce_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      share_hit[i] = lane.lane_res_valid[i] && !hit[i] &&
                     (lane.lane_res_hash[i*HASH_W +: HASH_W] <= share_target);
      if (share_oh[i]) share_nonce_d = share_nonce_d | lane.lane_res_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  // Share pulse, latest share nonce and saturating share counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share_pulse <= 1'b0;
      share_nonce <= '0;
      share_count <= '0;
    end else begin
      share_pulse <= 1'b0;
      if (start_ok) begin
        share_count <= '0;
      end else if ((state_q == ST_RUN) && !stop && share_any) begin
        share_pulse <= 1'b1;
        share_nonce <= share_nonce_d;
        if (share_count != '1) share_count <= share_count + 32'd1;
      end
    end
  end
`endif

  // Outputs; current_nonce shows the winner while FOUND.
  always_comb begin
    state_out           = state_q;
    current_nonce       = (state_q == ST_FOUND) ? found_q : nxt_q[NONCE_W-1:0];
    found_nonce         = found_q;
    lane.lane_job_valid = offer_q;
    lane.lane_job_nonce = offer_nonce_q;
    lane.lane_job_count = offer_count_q;
    lane.lane_abort     = abort_q;
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler (4 lanes, 256-nonce chunks).
// The share section is built when NONCE_SCHED_SHARE_EN is defined.
module tb_nonce_scheduler;
  import miner_pkg::*;

  localparam int NL = 4;
  localparam int NW = 32;
  localparam int CL = 8;
  localparam int HW = 256;
  localparam int CW = CL + 1;
  localparam logic [HW-1:0] T_BLK = {88'h00000000000000000440C4, 168'h0};
  localparam logic [HW-1:0] H_LOW = {88'h000000000000000003ABCD, 168'h5};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NW-1:0] nonce_base = '0;
  logic [NW-1:0] nonce_limit = '0;
  logic [HW-1:0] target = '0;
  logic [2:0]    state_out;
  logic [NW-1:0] current_nonce;
  logic [NW-1:0] found_nonce;
`ifdef NONCE_SCHED_SHARE_EN
  logic [HW-1:0] share_target = '0;
  logic          share_pulse;
  logic [NW-1:0] share_nonce;
  logic [31:0]   share_count;
`endif

  nonce_scheduler_if #(.NUM_LANES(NL), .NONCE_W(NW), .CHUNK_LOG2(CL), .HASH_W(HW)) lif ();

  nonce_scheduler #(.NUM_LANES(NL), .NONCE_W(NW), .CHUNK_LOG2(CL), .HASH_W(HW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .nonce_base    (nonce_base),
    .nonce_limit   (nonce_limit),
    .target        (target),
    .lane          (lif),
`ifdef NONCE_SCHED_SHARE_EN
    .share_target  (share_target),
    .share_pulse   (share_pulse),
    .share_nonce   (share_nonce),
    .share_count   (share_count),
`endif
    .state_out     (state_out),
    .current_nonce (current_nonce),
    .found_nonce   (found_nonce)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [NW+CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n clocks, landing 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k = 0;
    while (state_out !== st && k < budget) begin
      cyc(1);
      k++;
    end
    check(tag, 64'(state_out), 64'(st));
  endtask

  task automatic start_run(input logic [NW-1:0] b, input logic [NW-1:0] l, input logic [HW-1:0] t);
    nonce_base = b;
    nonce_limit = l;
    target = t;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  // Wait for an offer on lane ln, score it against the expected queue, then accept it.
  task automatic take_job(input int ln, input string tag);
    int k = 0;
    logic [NW+CW-1:0] e;
    while (lif.lane_job_valid[ln] !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    check({tag, "_valid"}, 64'(lif.lane_job_valid), 64'(1) << ln);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check({tag, "_nonce"}, 64'(lif.lane_job_nonce[ln*NW +: NW]), 64'(e[NW+CW-1:CW]));
    check({tag, "_count"}, 64'(lif.lane_job_count[ln*CW +: CW]), 64'(e[CW-1:0]));
    lif.lane_job_ready[ln] = 1'b1;
    cyc(1);
    lif.lane_job_ready[ln] = 1'b0;
  endtask

  task automatic result(input int ln, input logic [NW-1:0] n, input logic [HW-1:0] h);
    lif.lane_res_valid[ln] = 1'b1;
    lif.lane_res_nonce[ln*NW +: NW] = n;
    lif.lane_res_hash[ln*HW +: HW] = h;
    cyc(1);
    lif.lane_res_valid[ln] = 1'b0;
  endtask

  task automatic done(input int ln);
    lif.lane_job_done[ln] = 1'b1;
    cyc(1);
    lif.lane_job_done[ln] = 1'b0;
  endtask

  initial begin
    lif.lane_job_ready = '0;
    lif.lane_res_valid = '0;
    lif.lane_res_nonce = '0;
    lif.lane_res_hash  = '0;
    lif.lane_job_done  = '0;
    cyc(3);
    check("rst_state", 64'(state_out), 64'(ST_IDLE));
    check("rst_valid", 64'(lif.lane_job_valid), 64'h0);
    check("rst_abort", 64'(lif.lane_abort), 64'h0);
    check("rst_current", 64'(current_nonce), 64'h0);
    check("rst_found", 64'(found_nonce), 64'h0);
    check("rst_job_nonce", 64'(lif.lane_job_nonce[NW-1:0]), 64'h0);
    rst_n = 1'b1;
    cyc(1);

    // Four full chunks over [0, 0x3FF], no hits, exhaustion after the last done.
    start_run(32'h0, 32'h3FF, '0);
    check("t1_run", 64'(state_out), 64'(ST_RUN));
    exp_q.push_back({32'h000, 9'd256});
    exp_q.push_back({32'h100, 9'd256});
    exp_q.push_back({32'h200, 9'd256});
    exp_q.push_back({32'h300, 9'd256});
    take_job(0, "t1_j0");
    take_job(1, "t1_j1");
    take_job(2, "t1_j2");
    take_job(3, "t1_j3");
    result(0, 32'h5, 256'h1);
    check("t1_nohit_state", 64'(state_out), 64'(ST_RUN));
    check("t1_no_offer", 64'(lif.lane_job_valid), 64'h0);
    check("t1_current", 64'(current_nonce), 64'h400);
    done(0);
    done(1);
    done(2);
    check("t1_busy_run", 64'(state_out), 64'(ST_RUN));
    done(3);
    wait_state(ST_EXHAUSTED, 4, "t1_exhausted");

    // Restart from EXHAUSTED; lane 2 finds a block.
    start_run(32'h9c9a4d00, 32'h9c9affff, T_BLK);
    exp_q.push_back({32'h9c9a4d00, 9'd256});
    exp_q.push_back({32'h9c9a4e00, 9'd256});
    exp_q.push_back({32'h9c9a4f00, 9'd256});
    take_job(0, "t2_j0");
    take_job(1, "t2_j1");
    take_job(2, "t2_j2");
    result(2, 32'h9c9a4fc0, H_LOW);
    check("t2_found", 64'(state_out), 64'(ST_FOUND));
    check("t2_found_nonce", 64'(found_nonce), 64'h9c9a4fc0);
    check("t2_current", 64'(current_nonce), 64'h9c9a4fc0);
    check("t2_abort", 64'(lif.lane_abort), 64'h1);
    check("t2_offers_cleared", 64'(lif.lane_job_valid), 64'h0);
    cyc(1);
    check("t2_abort_once", 64'(lif.lane_abort), 64'h0);
    check("t2_found_hold", 64'(state_out), 64'(ST_FOUND));

    // Lanes 1 and 3 hit together (lane 1 at hash == target); lane 0 misses by one.
    stop_pulse();
    check("t3_idle", 64'(state_out), 64'(ST_IDLE));
    start_run(32'h0, 32'h3FF, T_BLK);
    exp_q.push_back({32'h000, 9'd256});
    exp_q.push_back({32'h100, 9'd256});
    exp_q.push_back({32'h200, 9'd256});
    exp_q.push_back({32'h300, 9'd256});
    take_job(0, "t3_j0");
    take_job(1, "t3_j1");
    take_job(2, "t3_j2");
    take_job(3, "t3_j3");
    lif.lane_res_valid = 4'b1011;
    lif.lane_res_nonce[0*NW +: NW] = 32'h050;
    lif.lane_res_hash[0*HW +: HW]  = T_BLK + 256'h1;
    lif.lane_res_nonce[1*NW +: NW] = 32'h150;
    lif.lane_res_hash[1*HW +: HW]  = T_BLK;
    lif.lane_res_nonce[3*NW +: NW] = 32'h350;
    lif.lane_res_hash[3*HW +: HW]  = '0;
    cyc(1);
    lif.lane_res_valid = '0;
    check("t3_found", 64'(state_out), 64'(ST_FOUND));
    check("t3_found_nonce", 64'(found_nonce), 64'h150);
    check("t3_abort", 64'(lif.lane_abort), 64'h1);

    // Top-of-range chunk: one short job, pointer steps past all-ones without wrapping.
    stop_pulse();
    check("t4_idle", 64'(state_out), 64'(ST_IDLE));
    start_run(32'hFFFFFF80, 32'hFFFFFFFF, '0);
    exp_q.push_back({32'hFFFFFF80, 9'd128});
    take_job(0, "t4_j0");
    cyc(3);
    check("t4_no_second_job", 64'(lif.lane_job_valid), 64'h0);
    check("t4_still_run", 64'(state_out), 64'(ST_RUN));
    done(0);
    wait_state(ST_EXHAUSTED, 4, "t4_exhausted");

    // Stalled offer stays stable; stop aborts, DRAIN ignores results for 2 cycles.
    start_run(32'h1000, 32'h1FFF, '0);
    cyc(1);
    check("t5_offer", 64'(lif.lane_job_valid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t5_stall_valid", 64'(lif.lane_job_valid), 64'h1);
      check("t5_stall_nonce", 64'(lif.lane_job_nonce[NW-1:0]), 64'h1000);
      check("t5_stall_count", 64'(lif.lane_job_count[CW-1:0]), 64'd256);
    end
    stop_pulse();
    check("t5_drain", 64'(state_out), 64'(ST_DRAIN));
    check("t5_abort", 64'(lif.lane_abort), 64'h1);
    check("t5_drain_clear", 64'(lif.lane_job_valid), 64'h0);
    result(0, 32'h1234, '0);
    check("t5_drain2", 64'(state_out), 64'(ST_DRAIN));
    check("t5_abort_once", 64'(lif.lane_abort), 64'h0);
    check("t5_found_kept", 64'(found_nonce), 64'h150);
    cyc(1);
    check("t5_idle", 64'(state_out), 64'(ST_IDLE));

    // Empty range: straight to EXHAUSTED, nothing offered.
    start_run(32'd10, 32'd5, '0);
    check("t6_exhausted", 64'(state_out), 64'(ST_EXHAUSTED));
    cyc(2);
    check("t6_no_offer", 64'(lif.lane_job_valid), 64'h0);

    // start and stop together: stop wins.
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    check("t7_stop_wins", 64'(state_out), 64'(ST_IDLE));

`ifdef NONCE_SCHED_SHARE_EN
    share_target = 256'hFFFF;
    start_run(32'h0, 32'hFF, '0);
    exp_q.push_back({32'h0, 9'd256});
    take_job(0, "sh_j0");
    result(0, 32'h11, 256'h10);
    check("sh_pulse1", 64'(share_pulse), 64'h1);
    check("sh_nonce1", 64'(share_nonce), 64'h11);
    result(0, 32'h22, 256'h20);
    check("sh_pulse2", 64'(share_pulse), 64'h1);
    result(0, 32'h33, 256'h10000);
    check("sh_no_pulse", 64'(share_pulse), 64'h0);
    result(0, 32'h44, 256'h30);
    check("sh_pulse3", 64'(share_pulse), 64'h1);
    check("sh_nonce3", 64'(share_nonce), 64'h44);
    check("sh_count", 64'(share_count), 64'd3);
    stop_pulse();
    cyc(2);
    check("sh_idle", 64'(state_out), 64'(ST_IDLE));
`endif

    // Asynchronous reset in the middle of a search.
    start_run(32'h0, 32'hFFFF, '0);
    exp_q.push_back({32'h0, 9'd256});
    take_job(0, "rm_j0");
    cyc(1);
    check("rm_pre_offer", 64'(lif.lane_job_valid), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_state", 64'(state_out), 64'(ST_IDLE));
    check("rm_valid", 64'(lif.lane_job_valid), 64'h0);
    check("rm_current", 64'(current_nonce), 64'h0);
    check("rm_found", 64'(found_nonce), 64'h0);
    check("rm_abort", 64'(lif.lane_abort), 64'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
